// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: two-channel write arbiter and watermark drain sequencer.
// Define FIFO_WR_ARB_PRIO_EN for fixed A priority instead of round-robin.
module fifo_wr_arb #(
  parameter int DATA_W  = 8,
  parameter int USEDW_W = 8,
  parameter int HI_WM   = 240,
  parameter int LO_WM   = 16
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               a_valid,
  input  logic [DATA_W-1:0]  a_data,
  output logic               a_ready,
  input  logic               b_valid,
  input  logic [DATA_W-1:0]  b_data,
  output logic               b_ready,
  output logic               fifo_wrreq,
  output logic [DATA_W-1:0]  fifo_data,
  output logic               fifo_rdreq,
  input  logic               fifo_full,
  input  logic               fifo_empty,
  input  logic [USEDW_W-1:0] fifo_usedw,
  output logic               out_valid,
  output logic               drain_active,
  output logic               last_grant
);

  localparam logic [USEDW_W:0] HI = HI_WM[USEDW_W:0];
  localparam logic [USEDW_W:0] LO = LO_WM[USEDW_W:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [USEDW_W:0] fill_w;
  logic [USEDW_W:0] fill_r;
  logic             tie;
  logic             grant;
  logic             accept;
  logic             xfer;
  logic             rd_nx;

  // usedw lags our own registered requests by a cycle; fold them back in
  assign fill_w = {1'b0, fifo_usedw}
                + {{USEDW_W{1'b0}}, fifo_wrreq};
  assign fill_r = {1'b0, fifo_usedw}
                - {{USEDW_W{1'b0}}, fifo_rdreq};

`ifdef FIFO_WR_ARB_PRIO_EN
  assign tie = 1'b0;
`else
  assign tie = ~last_grant;
`endif

  // grant: lone requester wins, ties resolved by tie
  always_comb begin
    grant = 1'b0;
    if (a_valid && b_valid) begin
      grant = tie;
    end else if (b_valid) begin
      grant = 1'b1;
    end
  end

  assign accept = (state == FILL) && !fifo_full
                && (fill_w < HI);
  assign a_ready = accept && !grant;
  assign b_ready = accept && grant;
  assign xfer = (a_valid && a_ready)
              || (b_valid && b_ready);
  assign drain_active = (state == DRAIN);

  // next state and next read request
  always_comb begin
    state_nx = state;
    rd_nx    = 1'b0;
    unique case (state)
      IDLE: state_nx = FILL;
      FILL: begin
        if (fifo_full || fill_w >= HI) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        rd_nx = (fill_r > LO) && !fifo_empty;
        if (!rd_nx) begin
          state_nx = FILL;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // registered fifo controls and grant history
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      fifo_wrreq <= 1'b0;
      fifo_data  <= '0;
      fifo_rdreq <= 1'b0;
      out_valid  <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      fifo_wrreq <= xfer;
      if (xfer) begin
        fifo_data  <= grant ? b_data : a_data;
        last_grant <= grant;
      end
      fifo_rdreq <= rd_nx;
      out_valid  <= fifo_rdreq;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: scoreboard bench with behavioural fifo models
// for a default instance and a HI_WM=254/LO_WM=0 instance.
module tb_fifo_wr_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // ---------------- instance 1 (default params)
  logic       rst_n, a_valid, b_valid;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready, wrreq, rdreq;
  logic       out_valid, drain, lgrant;
  logic [7:0] wdata, usedw;
  logic       full, empty, clr1;
  logic [7:0] mem1 [256];
  logic [7:0] wp1, rp1, q1;
  logic [8:0] cnt1;

  assign usedw = cnt1[7:0];
  assign full  = (cnt1 == 9'd256);
  assign empty = (cnt1 == 9'd0);

  fifo_wr_arb dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data),
    .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data),
    .b_ready(b_ready),
    .fifo_wrreq(wrreq), .fifo_data(wdata),
    .fifo_rdreq(rdreq),
    .fifo_full(full), .fifo_empty(empty),
    .fifo_usedw(usedw),
    .out_valid(out_valid),
    .drain_active(drain),
    .last_grant(lgrant)
  );

  always @(posedge clk) begin
    if (clr1) begin
      wp1 <= 0; rp1 <= 0; cnt1 <= 0; q1 <= 0;
    end else begin
      if (wrreq && !full) begin
        mem1[wp1] <= wdata;
        wp1 <= wp1 + 8'd1;
      end
      if (rdreq && !empty) begin
        q1 <= mem1[rp1];
        rp1 <= rp1 + 8'd1;
      end
      cnt1 <= cnt1 + 9'(wrreq && !full)
                   - 9'(rdreq && !empty);
    end
  end

  // ---------------- instance 2 (drain to empty)
  logic       rst2_n, a2_valid, a2_ready, b2_ready;
  logic [7:0] a2_data, data2, usedw2, q2;
  logic       wr2, rd2, ov2, drain2, lg2;
  logic       full2, empty2, force2, clr2;
  logic [7:0] mem2 [256];
  logic [7:0] wp2, rp2;
  logic [8:0] cnt2;

  assign usedw2 = cnt2[7:0];
  assign full2  = (cnt2 == 9'd256) || force2;
  assign empty2 = (cnt2 == 9'd0);

  fifo_wr_arb #(.HI_WM(254), .LO_WM(0)) dut2 (
    .sys_clk(clk), .sys_rst_n(rst2_n),
    .a_valid(a2_valid), .a_data(a2_data),
    .a_ready(a2_ready),
    .b_valid(1'b0), .b_data(8'h00),
    .b_ready(b2_ready),
    .fifo_wrreq(wr2), .fifo_data(data2),
    .fifo_rdreq(rd2),
    .fifo_full(full2), .fifo_empty(empty2),
    .fifo_usedw(usedw2),
    .out_valid(ov2),
    .drain_active(drain2),
    .last_grant(lg2)
  );

  always @(posedge clk) begin
    if (clr2) begin
      wp2 <= 0; rp2 <= 0; cnt2 <= 0; q2 <= 0;
    end else begin
      if (wr2 && cnt2 != 9'd256) begin
        mem2[wp2] <= data2;
        wp2 <= wp2 + 8'd1;
      end
      if (rd2 && !empty2) begin
        q2 <= mem2[rp2];
        rp2 <= rp2 + 8'd1;
      end
      cnt2 <= cnt2 + 9'(wr2 && cnt2 != 9'd256)
                   - 9'(rd2 && !empty2);
    end
  end

  // ---------------- scoreboard / monitors
  logic [8:0] exp_wr [$];
  logic [7:0] exp_rd [$];
  logic [8:0] e;
  logic [7:0] last_q, last_q2, q2_exp;
  int wr_cnt = 0, rd_cnt = 0;
  int wr2_cnt = 0, rd2_cnt = 0;

  always @(negedge clk) begin
    chk("wr_rd_excl", int'(wrreq && rdreq), 0);
    if (wrreq) begin
      wr_cnt++;
      if (exp_wr.size() == 0) begin
        chk("wr_unexpected", 1, 0);
      end else begin
        e = exp_wr.pop_front();
        chk("wr_data", int'(wdata), int'(e[7:0]));
        chk("last_grant", int'(lgrant), int'(e[8]));
      end
    end
    if (rdreq) rd_cnt++;
    if (out_valid) begin
      if (exp_rd.size() == 0) begin
        chk("rd_unexpected", 1, 0);
      end else begin
        chk("q_data", int'(q1),
            int'(exp_rd.pop_front()));
      end
      last_q = q1;
    end
  end

  always @(negedge clk) begin
    chk("rd_past_empty", int'(rd2 && empty2), 0);
    if (wr2) wr2_cnt++;
    if (rd2) rd2_cnt++;
    if (ov2) begin
      chk("q2_order", int'(q2), int'(q2_exp));
      q2_exp = q2_exp + 8'd1;
      last_q2 = q2;
    end
  end

  // ---------------- stimulus
  logic hs_a, hs_b;
  bit   model_last;
  bit   count_mode;

  task automatic step();
    int ch;
    @(negedge clk);
    hs_a = rst_n && a_valid && a_ready;
    hs_b = rst_n && b_valid && b_ready;
    if (hs_a || hs_b) begin
      chk("one_grant", int'(hs_a && hs_b), 0);
`ifdef FIFO_WR_ARB_PRIO_EN
      ch = a_valid ? 0 : 1;
`else
      ch = (a_valid && b_valid) ? int'(!model_last)
         : (b_valid ? 1 : 0);
`endif
      chk("grant_ch", int'(hs_b), ch);
      model_last = ch[0];
      exp_wr.push_back({hs_b, hs_b ? b_data : a_data});
      exp_rd.push_back(hs_b ? b_data : a_data);
    end
    @(posedge clk); #1;
    if (hs_a) a_data = count_mode ? a_data + 8'd1
                                  : 8'($urandom);
    if (hs_b) b_data = 8'($urandom);
  endtask

  task automatic step2();
    logic hs;
    @(negedge clk);
    hs = a2_valid && a2_ready;
    @(posedge clk); #1;
    if (hs) a2_data = a2_data + 8'd1;
  endtask

  initial begin
    int n, n_hs, idle, base, words;
    rst_n = 0; clr1 = 1;
    a_valid = 1; b_valid = 1;
    a_data = 8'($urandom); b_data = 8'($urandom);
    count_mode = 0; model_last = 1;
    rst2_n = 0; clr2 = 1; a2_valid = 0;
    a2_data = 0; force2 = 0; q2_exp = 0;
    last_q = 0; last_q2 = 0;

    // reset held 3 cycles with both channels valid
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_wrreq", int'(wrreq), 0);
      chk("rst_rdreq", int'(rdreq), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_drain", int'(drain), 0);
      chk("rst_data", int'(wdata), 0);
      chk("rst_last_grant", int'(lgrant), 1);
      chk("rst_a_ready", int'(a_ready), 0);
      chk("rst_b_ready", int'(b_ready), 0);
    end
    rst_n = 1; clr1 = 0;

    // first cycle after release: idle; second: A
    step();
    chk("first_cyc_hs", int'(hs_a || hs_b), 0);
    step();
    chk("second_cyc_a", int'(hs_a), 1);
    chk("second_cyc_b", int'(hs_b), 0);

    // round-robin fill to the high watermark
    n_hs = 1; idle = 0; n = 0;
    while (!drain && n < 1000) begin
      step(); n++;
      if (hs_a || hs_b) n_hs++;
      else idle++;
    end
    chk("p1_drain_reached", int'(drain), 1);
    chk("p1_writes", n_hs, 240);
    chk("p1_idle", idle, 1);
    base = rd_cnt; n = 0;
    while (drain && n < 1000) begin
      step(); n++;
    end
    chk("p1_reads", rd_cnt - base, 224);
    chk("p1_usedw", int'(usedw), 16);
    a_valid = 0; b_valid = 0;

    // restart from an empty fifo, A only, counting data
    @(posedge clk); #1;
    rst_n = 0; clr1 = 1;
    repeat (2) begin @(posedge clk); #1; end
    chk("p1_wr_drained", exp_wr.size(), 0);
    exp_rd.delete();
    model_last = 1; count_mode = 1; a_data = 0;
    rst_n = 1; clr1 = 0; a_valid = 1;
    n_hs = 0; n = 0;
    while (!drain && n < 1000) begin
      step(); n++;
      if (hs_a) n_hs++;
    end
    chk("p2_writes", n_hs, 240);
    base = rd_cnt; n = 0;
    while (drain && n < 1000) begin
      step(); n++;
    end
    chk("p2_reads", rd_cnt - base, 224);
    chk("p2_usedw", int'(usedw), 16);
    step();
    chk("p2_last_q", int'(last_q), 223);

    // refill, then reset after 50 reads
    n = 0;
    while (!drain && n < 1000) begin
      step(); n++;
    end
    chk("p3_drain_reached", int'(drain), 1);
    base = rd_cnt; n = 0;
    while (!((rd_cnt - base == 49) && rdreq)
           && n < 500) begin
      @(posedge clk); #1; n++;
    end
    rst_n = 0;
    @(posedge clk); #1;
    chk("p3_rst_rdreq", int'(rdreq), 0);
    chk("p3_rst_drain", int'(drain), 0);
    chk("p3_rst_a_ready", int'(a_ready), 0);
    chk("p3_rst_usedw", int'(usedw), 190);
    model_last = 1;
    rst_n = 1;
    n = 0; hs_a = 0;
    while (!hs_a && n < 10) begin
      step(); n++;
    end
    chk("p3_resume_wr", int'(wrreq), 1);
    chk("p3_resume_usedw", int'(usedw), 190);
    chk("p3_reads", rd_cnt - base, 50);
    a_valid = 0;
    repeat (3) step();
    chk("p3_wr_drained", exp_wr.size(), 0);

    // drain to empty after forced full
    repeat (2) begin @(posedge clk); #1; end
    rst2_n = 1; clr2 = 0; a2_valid = 1;
    n = 0;
    while (cnt2 < 9'd100 && n < 500) begin
      step2(); n++;
    end
    force2 = 1;
    n = 0;
    while (!drain2 && n < 10) begin
      @(posedge clk); #1; n++;
    end
    chk("p4_drain_on_full", int'(drain2), 1);
    force2 = 0; a2_valid = 0;
    words = int'(cnt2);
    base = rd2_cnt; n = 0;
    while (drain2 && n < 500) begin
      @(posedge clk); #1; n++;
    end
    chk("p4_reads", rd2_cnt - base, words);
    chk("p4_writes", wr2_cnt, words);
    chk("p4_usedw", int'(usedw2), 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("p4_empty", int'(empty2), 1);
    chk("p4_rdreq_idle", int'(rd2), 0);
    chk("p4_drain_off", int'(drain2), 0);
    chk("p4_last_q", int'(last_q2), words - 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
